// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
//   state_t    : scheduler FSM states
//   N_REQ      : number of requesters (one per 4:1 mux input)
//   SEL_W      : width of the mux select {sel1,sel0}
//   idx_to_sel : requester index -> mux select encoding
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Requester k drives mux input i(k+1), so the select is simply k.
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating priority encoder: finds the first asserted request starting at
// (ptr+1) mod 4 and wrapping upward. Purely combinational.
//   req     [3:0] in  : request lines
//   ptr     [1:0] in  : index of the last owner
//   any_req       out : at least one request is high
//   pick    [1:0] out : chosen requester index (0 when any_req is low)
module mux_rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any_req,
    output logic [SEL_W-1:0] pick
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = '0;
        // Walk the ring from ptr+1; the first hit wins, later hits are ignored.
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i + 1);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared 4:1 mux. Grants one requester at a time for
// at most HOLD_CYCLES cycles, then inserts a one-cycle gap before the next
// tenure so the select never changes while y_valid is high.
//   clk        in       : clock, rising edge
//   rst_n      in       : synchronous active-low reset
//   req  [3:0] in       : request lines, req[k] wants mux input i(k+1)
//   grant[3:0] out      : registered one-hot grant, 0000 when no owner
//   sel0/sel1  out      : registered mux select, {sel1,sel0} = owner index
//   y_valid    out      : mux output carries the owner's data
//   busy       out      : FSM is not idle
//   preempted  out      : one-cycle pulse in the gap after a tenure that
//                         expired while its owner was still requesting
module mux_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       sel0,
    output logic       sel1,
    output logic       y_valid,
    output logic       busy,
    output logic       preempted
);

    import mux_sched_pkg::*;

    if (N_REQ != mux_sched_pkg::N_REQ || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        (2 ** CNT_W) <= HOLD_CYCLES) begin : g_bad_param
        $error("mux_rr_scheduler: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [3:0]       grant_n;
    logic             y_valid_n, pre_n;

    logic             any_req;
    logic [SEL_W-1:0] pick;

    mux_rr_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .any_req (any_req),
        .pick    (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= 2'd3;   // first pick after reset starts at requester 0
            sel       <= '0;
            grant     <= '0;
            y_valid   <= 1'b0;
            preempted <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            grant     <= grant_n;
            y_valid   <= y_valid_n;
            preempted <= pre_n;
        end
    end

    // While in OWN, ptr holds the current owner index.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        sel_n     = sel;       // select only moves when a new tenure starts
        grant_n   = grant;
        y_valid_n = y_valid;
        pre_n     = 1'b0;
        case (state)
            IDLE, GAP: begin
                grant_n   = '0;
                y_valid_n = 1'b0;
                state_n   = IDLE;
                if (any_req) begin
                    state_n   = OWN;
                    grant_n   = 4'b0001 << pick;
                    sel_n     = idx_to_sel(pick);
                    y_valid_n = 1'b1;
                    cnt_n     = '0;
                    ptr_n     = pick;
                end
            end
            OWN: begin
                // Release is checked first so it wins over a same-edge expiry.
                if (!req[ptr]) begin
                    state_n   = GAP;
                    grant_n   = '0;
                    y_valid_n = 1'b0;
                    cnt_n     = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = GAP;
                    grant_n   = '0;
                    y_valid_n = 1'b0;
                    cnt_n     = '0;
                    pre_n     = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                grant_n   = '0;
                y_valid_n = 1'b0;
            end
        endcase
    end

    assign sel0 = sel[0];
    assign sel1 = sel[1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
module tb_mux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       sel0, sel1, y_valid, busy, preempted;

    int n_cmp = 0;
    int n_bad = 0;

    mux_rr_scheduler #(.N_REQ(4), .HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .sel0      (sel0),
        .sel1      (sel1),
        .y_valid   (y_valid),
        .busy      (busy),
        .preempted (preempted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] sel;
        logic       yv;
        logic       bz;
        logic       pre;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] s, input logic yv, input logic bz,
                                input logic pre);
        vec_t v;
        v.rst_n = r; v.req = q; v.g = g; v.sel = s; v.yv = yv; v.bz = bz; v.pre = pre;
        return v;
    endfunction

    // Apply inputs, clock one edge, sample 1 time unit later.
    task automatic step(input string name, input logic r, input logic [3:0] q,
                        input logic [3:0] eg, input logic [1:0] es, input logic eyv,
                        input logic ebz, input logic epre);
        logic [8:0] act, exp;
        rst_n = r;
        req   = q;
        @(posedge clk);
        #1;
        act = {grant, sel1, sel0, y_valid, busy, preempted};
        exp = {eg, es, eyv, ebz, epre};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got grant=%b sel=%b yv=%b busy=%b pre=%b, want grant=%b sel=%b yv=%b busy=%b pre=%b",
                     name, act[8:5], act[4:3], act[2], act[1], act[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;

        //            rst  req      grant    sel    yv  busy pre
        // reset hold, then release with all requesting
        tbl[0]  = mk(0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0);
        tbl[1]  = mk(0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0);
        tbl[2]  = mk(1, 4'b1111, 4'b0001, 2'b00, 1, 1, 0);
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);
        // single short request on i3, two granted cycles, gap holds sel, idle
        tbl[4]  = mk(1, 4'b0100, 4'b0100, 2'b10, 1, 1, 0);
        tbl[5]  = mk(1, 4'b0100, 4'b0100, 2'b10, 1, 1, 0);
        tbl[6]  = mk(1, 4'b0000, 4'b0000, 2'b10, 0, 1, 0);
        tbl[7]  = mk(1, 4'b0000, 4'b0000, 2'b10, 0, 0, 0);
        // owner 1, then 1001 -> index 3, then wrap to index 0
        tbl[8]  = mk(1, 4'b0010, 4'b0010, 2'b01, 1, 1, 0);
        tbl[9]  = mk(1, 4'b1001, 4'b0000, 2'b01, 0, 1, 0);
        tbl[10] = mk(1, 4'b1001, 4'b1000, 2'b11, 1, 1, 0);
        tbl[11] = mk(1, 4'b0001, 4'b0000, 2'b11, 0, 1, 0);
        tbl[12] = mk(1, 4'b1001, 4'b0001, 2'b00, 1, 1, 0);
        tbl[13] = mk(1, 4'b1001, 4'b0001, 2'b00, 1, 1, 0);
        tbl[14] = mk(1, 4'b1001, 4'b0001, 2'b00, 1, 1, 0);
        tbl[15] = mk(1, 4'b1001, 4'b0001, 2'b00, 1, 1, 0);
        // release on the expiry edge: release wins, no preempted pulse
        tbl[16] = mk(1, 4'b1000, 4'b0000, 2'b00, 0, 1, 0);
        tbl[17] = mk(1, 4'b1000, 4'b1000, 2'b11, 1, 1, 0);
        // reset mid-tenure with owner 2
        tbl[18] = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);
        tbl[19] = mk(1, 4'b0100, 4'b0100, 2'b10, 1, 1, 0);
        tbl[20] = mk(1, 4'b0100, 4'b0100, 2'b10, 1, 1, 0);
        tbl[21] = mk(0, 4'b0100, 4'b0000, 2'b00, 0, 0, 0);
        tbl[22] = mk(1, 4'b0100, 4'b0100, 2'b10, 1, 1, 0);
        tbl[23] = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 24; i++)
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].g,
                 tbl[i].sel, tbl[i].yv, tbl[i].bz, tbl[i].pre);

        // Max tenure: a lone requester gets 4 cycles, a preempting gap, repeat.
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++)
                step($sformatf("hold_p%0d_c%0d", p, c), 1'b1, 4'b0001,
                     4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);
            step($sformatf("hold_p%0d_gap", p), 1'b1, 4'b0001,
                 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
        end

        step("rr_reset", 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Round robin with everyone requesting: 0,1,2,3,0 each for 4 cycles.
        for (int t = 0; t < 5; t++) begin
            logic [1:0] k;
            logic [3:0] g;
            k = 2'(t % 4);
            g = 4'b0001 << k;
            for (int c = 0; c < 4; c++)
                step($sformatf("rr_t%0d_c%0d", t, c), 1'b1, 4'b1111,
                     g, k, 1'b1, 1'b1, 1'b0);
            step($sformatf("rr_t%0d_gap", t), 1'b1, 4'b1111,
                 4'b0000, k, 1'b0, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
